// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uc_pkg
// Purpose  : Shared constants for the Booth multiplier control unit.
//            - FSM state encoding (3 bits).
//            - Booth pair decode results and the {q0,qm1} decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package uc_pkg;

  // FSM state encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] EVAL  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Booth pair decode
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;

  // {Q[0], Q-1}: 10 starts a run of ones (subtract M),
  // 01 ends a run of ones (add M), 00/11 are inside a run (no operation).
  function automatic logic [1:0] booth_decode(input logic q0, input logic qm1);
    logic [1:0] op;
    case ({q0, qm1})
      2'b10:   op = OP_SUB;
      2'b01:   op = OP_ADD;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_desc.sv
`default_nettype none
// ============================================================================
// Module   : contador_desc
// Purpose  : Loadable down-counter that tracks the remaining Booth iterations.
// Ports    : clk        in   rising-edge clock
//            reset      in   asynchronous active-high reset (count -> 0)
//            carga      in   load count with valor (priority over decrementa)
//            valor      in   [CW-1:0] load value
//            decrementa in   decrement count by one
//            cuenta     out  [CW-1:0] current count
// Revision : 1.0 - initial release
// ============================================================================
module contador_desc #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carga,
  input  logic [CW-1:0] valor,
  input  logic          decrementa,
  output logic [CW-1:0] cuenta
);

  logic [CW-1:0] r_cuenta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cuenta <= '0;
    end else if (carga) begin
      r_cuenta <= valor;
    end else if (decrementa) begin
      r_cuenta <= r_cuenta - 1'b1;
    end
  end

  assign cuenta = r_cuenta;

endmodule
`default_nettype wire

// File: rtl/unidad_control_booth.sv
`default_nettype none
// ============================================================================
// Module   : unidad_control_booth
// Purpose  : Moore control unit for a radix-2 Booth multiplier datapath.
//            Sequences INIT -> (EVAL -> SHIFT) x N -> DONE under a level
//            inicio/fin handshake.
// Ports    : clk       in   rising-edge clock
//            reset     in   asynchronous active-high reset (forces IDLE)
//            inicio    in   start request, level
//            q0        in   datapath Q[0]
//            qm1       in   datapath Q-1 flip-flop
//            carga_ini out  load M, Q; clear A and Q-1
//            carga_a   out  load A from adder/subtractor
//            resta     out  adder mode (1: A-M, 0: A+M)
//            desplaza  out  arithmetic shift right of A:Q:Q-1
//            fin       out  product valid in A:Q
// Revision : 1.0 - initial release
// ============================================================================
module unidad_control_booth #(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inicio,
  input  logic q0,
  input  logic qm1,
  output logic carga_ini,
  output logic carga_a,
  output logic resta,
  output logic desplaza,
  output logic fin
);

  import uc_pkg::*;

  localparam logic [CW-1:0] C_CARGA_N = CW'(N);
  localparam logic [CW-1:0] C_ULTIMA  = CW'(1);

  logic [2:0]    r_estado;
  logic [2:0]    w_estado_sig;
  logic          r_inicio;
  logic [CW-1:0] w_cuenta;
  logic [1:0]    w_op;

  // inicio is taken through one flop: the start and release decisions act on
  // a cleanly sampled level, so INIT follows one cycle after inicio is seen
  // high and IDLE follows one cycle after it is seen low in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inicio <= 1'b0;
    end else begin
      r_inicio <= inicio;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next-state logic; inicio is only observed in IDLE and DONE, so an
  // operation in flight cannot be aborted except by reset.
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      IDLE:    if (r_inicio) w_estado_sig = INIT;
      INIT:    w_estado_sig = EVAL;
      EVAL:    w_estado_sig = SHIFT;
      // The count still holds the pre-decrement value during SHIFT.
      SHIFT:   w_estado_sig = (w_cuenta == C_ULTIMA) ? DONE : EVAL;
      DONE:    if (!r_inicio) w_estado_sig = IDLE;
      default: w_estado_sig = IDLE;
    endcase
  end

  assign w_op = booth_decode(q0, qm1);

  // Output decode; q0/qm1 only move on carga_ini or desplaza edges, so they
  // are settled throughout EVAL.
  always_comb begin
    carga_ini = 1'b0;
    carga_a   = 1'b0;
    resta     = 1'b0;
    desplaza  = 1'b0;
    fin       = 1'b0;
    case (r_estado)
      INIT:  carga_ini = 1'b1;
      EVAL: begin
        carga_a = (w_op != OP_NONE);
        resta   = (w_op == OP_SUB);
      end
      SHIFT: desplaza = 1'b1;
      DONE:  fin = 1'b1;
      default: ;
    endcase
  end

  contador_desc #(
    .CW (CW)
  ) u_contador (
    .clk        (clk),
    .reset      (reset),
    .carga      (r_estado == INIT),
    .valor      (C_CARGA_N),
    .decrementa (r_estado == SHIFT),
    .cuenta     (w_cuenta)
  );

endmodule
`default_nettype wire

// File: tb/tb_unidad_control_booth.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidad_control_booth
// Purpose  : Self-checking bench for unidad_control_booth with a behavioural
//            Booth datapath closing the q0/qm1 loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidad_control_booth;

  logic clk = 1'b0;
  logic reset;
  logic inicio;
  logic q0, qm1;
  logic carga_ini, carga_a, resta, desplaza, fin;

  int checks   = 0;
  int failures = 0;

  // Expected output patterns {carga_ini, carga_a, resta, desplaza, fin}
  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_INI  = 5'b10000;
  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_ADD  = 5'b01000;
  localparam logic [4:0] E_SUB  = 5'b01100;
  localparam logic [4:0] E_SHF  = 5'b00010;
  localparam logic [4:0] E_FIN  = 5'b00001;

  typedef struct {
    logic [3:0] m;       // sign-extended multiplicand
    logic [2:0] q;       // multiplier
    logic [4:0] e1;      // expected outputs in EVAL 1..3
    logic [4:0] e2;
    logic [4:0] e3;
    logic [6:0] prod;    // expected A:Q
    bit         toggle;  // wiggle inicio while the operation is running
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  unidad_control_booth #(
    .N  (3),
    .CW (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .q0        (q0),
    .qm1       (qm1),
    .carga_ini (carga_ini),
    .carga_a   (carga_a),
    .resta     (resta),
    .desplaza  (desplaza),
    .fin       (fin)
  );

  // Behavioural datapath
  logic [3:0] op_m = '0;
  logic [2:0] op_q = '0;
  logic [3:0] dp_a = '0;
  logic [3:0] dp_m = '0;
  logic [2:0] dp_q = '0;
  logic       dp_qm1 = 1'b0;

  always @(posedge clk) begin
    if (carga_ini) begin
      dp_a   <= '0;
      dp_m   <= op_m;
      dp_q   <= op_q;
      dp_qm1 <= 1'b0;
    end else if (carga_a) begin
      dp_a <= resta ? (dp_a - dp_m) : (dp_a + dp_m);
    end else if (desplaza) begin
      {dp_a, dp_q, dp_qm1} <= {dp_a[3], dp_a, dp_q};
    end
  end

  assign q0  = dp_q[0];
  assign qm1 = dp_qm1;

  function automatic logic [4:0] outs();
    return {carga_ini, carga_a, resta, desplaza, fin};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Start an operation and check every cycle up to DONE; inicio stays high.
  task automatic run_op(input int idx, input vec_t v);
    logic [4:0] exp;
    @(negedge clk);
    op_m   = v.m;
    op_q   = v.q;
    inicio = 1'b1;
    @(posedge clk); #1;
    check($sformatf("v%0d k0", idx), {2'b00, outs()}, {2'b00, E_IDLE});
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      case (k)
        1:       exp = E_INI;
        2:       exp = v.e1;
        4:       exp = v.e2;
        6:       exp = v.e3;
        8:       exp = E_FIN;
        default: exp = E_SHF;
      endcase
      check($sformatf("v%0d k%0d", idx, k), {2'b00, outs()}, {2'b00, exp});
      if (v.toggle && k >= 2 && k <= 6) inicio = k[0];
      else inicio = 1'b1;
    end
    check($sformatf("v%0d prod", idx), {dp_a, dp_q}, v.prod);
  endtask

  // Drop inicio in DONE: fin holds one more cycle, then IDLE.
  task automatic drop_to_idle(input int idx);
    inicio = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d drop+1", idx), {2'b00, outs()}, {2'b00, E_FIN});
    @(posedge clk); #1;
    check($sformatf("v%0d drop+2", idx), {2'b00, outs()}, {2'b00, E_IDLE});
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{m: 4'b0011, q: 3'b010, e1: E_NONE, e2: E_SUB,  e3: E_ADD,  prod: 7'b0000110, toggle: 1'b0};
    tbl[1] = '{m: 4'b1100, q: 3'b000, e1: E_NONE, e2: E_NONE, e3: E_NONE, prod: 7'b0000000, toggle: 1'b0};
    tbl[2] = '{m: 4'b0011, q: 3'b111, e1: E_SUB,  e2: E_NONE, e3: E_NONE, prod: 7'b1111101, toggle: 1'b0};
    tbl[3] = '{m: 4'b1100, q: 3'b100, e1: E_NONE, e2: E_NONE, e3: E_SUB,  prod: 7'b0010000, toggle: 1'b0};
    tbl[4] = '{m: 4'b1111, q: 3'b101, e1: E_SUB,  e2: E_ADD,  e3: E_SUB,  prod: 7'b0000011, toggle: 1'b1};
    rv     = '{m: 4'b0010, q: 3'b011, e1: E_SUB,  e2: E_NONE, e3: E_ADD,  prod: 7'b0000110, toggle: 1'b0};

    reset  = 1'b1;
    inicio = 1'b0;
    #3;
    check("reset outs", {2'b00, outs()}, {2'b00, E_IDLE});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle after reset", {2'b00, outs()}, {2'b00, E_IDLE});

    for (int i = 0; i < 5; i++) begin
      run_op(i, tbl[i]);
      if (i == 0) begin
        // inicio held high: DONE persists, no retrigger
        for (int h = 0; h < 4; h++) begin
          @(posedge clk); #1;
          check($sformatf("hold %0d", h), {2'b00, outs()}, {2'b00, E_FIN});
        end
      end
      drop_to_idle(i);
    end

    // Reset pulse in the second SHIFT
    @(negedge clk);
    op_m   = 4'b0011;
    op_q   = 3'b010;
    inicio = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst pre shift2", {2'b00, outs()}, {2'b00, E_SHF});
    #2;
    reset  = 1'b1;
    inicio = 1'b0;
    #1;
    check("rst async outs", {2'b00, outs()}, {2'b00, E_IDLE});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst released idle", {2'b00, outs()}, {2'b00, E_IDLE});
    run_op(5, rv);
    drop_to_idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unidad_control_booth.md
# unidad_control_booth

- Moore-style control unit for the radix-2 Booth multiplier datapath (3-bit signed Q, 3-bit signed M sign-extended to 4 bits, 4-bit accumulator A, one Q-1 flip-flop).
- Sits directly upstream of the datapath:
  - samples the two Booth bits the datapath produces (Q[0] and Q-1);
  - drives the load, add/subtract and arithmetic-shift controls over N iterations;
  - reports completion through a level start/done handshake.

## Interface
Parameters:
- N, default 3: number of Booth iterations, equal to the multiplier width Q.
- CW, default 2: iteration counter width, ≥ clog2(N+1).

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces IDLE.
- inicio  in  1  start request, level-sensitive.
- q0  in  1  datapath Q[0].
- qm1  in  1  datapath Q-1 flip-flop output.
- carga_ini  out  1  load M and Q from operands; clear A and Q-1.
- carga_a  out  1  load A from the adder/subtractor output.
- resta  out  1  adder mode: 1 = A−M, 0 = A+M.
- desplaza  out  1  arithmetic shift right of A:Q:Q-1.
- fin  out  1  product valid in A:Q.

## Operation
- Reset value of every output is 0; state IDLE; counter 0.
- States: IDLE, INIT, EVAL, SHIFT, DONE.
- IDLE:
  - all outputs 0;
  - inicio=1 → INIT.
- INIT (1 cycle):
  - carga_ini=1;
  - counter ← N;
  - → EVAL.
- EVAL (1 cycle): decode {q0,qm1}:
  - 10: carga_a=1, resta=1 (A ← A−M).
  - 01: carga_a=1, resta=0 (A ← A+M).
  - 00 or 11: carga_a=0.
  - resta=0 whenever carga_a=0.
  - → SHIFT.
- SHIFT (1 cycle):
  - desplaza=1;
  - counter ← counter−1;
  - counter==1 at this cycle → DONE, else → EVAL.
- DONE:
  - fin=1, all other outputs 0;
  - stays while inicio=1;
  - inicio=0 → IDLE.
- Control signals are mutually exclusive per cycle: at most one of carga_ini, carga_a, desplaza is high.
- inicio changes during INIT/EVAL/SHIFT are ignored; an operation cannot be aborted except by reset.
- Outputs are decoded from state plus registered-stable q0/qm1. The datapath updates q0/qm1 only on desplaza or carga_ini edges, so EVAL sees settled values.

## Timing
- Latency: inicio sampled at edge t → INIT during cycle t+1 → alternating EVAL/SHIFT → fin high from edge t+2+2N (t+8 for N=3).
- Each iteration takes exactly 2 cycles, fixed regardless of operand values.
- fin is a level held until inicio falls. IDLE is re-entered one cycle after inicio is sampled low.
- New start: inicio must be seen low in DONE, then high again in IDLE. Holding inicio high does not retrigger.
- Reset asserted at any cycle:
  - outputs go to 0 immediately (asynchronous), state IDLE;
  - release is synchronous to the next edge;
  - the first start after release behaves as from power-up.

## Structure
- Shared package uc_pkg contains:
  - state encoding constants (IDLE=0, INIT=1, EVAL=2, SHIFT=3, DONE=4; 3-bit);
  - Booth pair decode constants (OP_NONE, OP_ADD, OP_SUB).
- Sub-module contador_desc: loadable down-counter with CW width, inputs carga/decrementa, output cuenta.
- FSM state register and output decode live in the top.
- A wrapper joining this block with the datapath (multiplicador_booth) is a separate block, not part of this one.

## Test plan
- Reset, then M=3, Q=2 (010). Required EVAL decisions per iteration: none / carga_a+resta=1 / carga_a+resta=0. fin 8 cycles after inicio; A:Q = 0000110 (+6).
- Q=0, M=−4: no carga_a in any EVAL; desplaza exactly 3 times; fin at cycle 8; product 0.
- Q=−1 (111), M=3: EVAL 1 subtracts; EVAL 2 and 3 do nothing; A:Q = 1111101 (−3).
- Hold inicio high after fin: stays in DONE with no second carga_ini. Drop inicio: IDLE next cycle. Raise again: new run starts.
- Reset pulse during the second SHIFT: outputs 0 asynchronously. Restart M=2, Q=3 → product 6 with full 8-cycle latency.
- Toggle inicio during EVAL/SHIFT: no effect on the control sequence or the cycle count.
